// File: rtl/speed_tick_gen_if.sv
// Control and status bundle for the speed tick generator.
// The master drives enable/restart/level; the slave (generator) returns tick, tier and phase.
interface speed_tick_gen_if;
  logic       enable;
  logic       restart;
  logic [3:0] level;
  logic       tick;
  logic [1:0] tier;
  logic       tier_changed;
  logic       phase;

  modport master (
    output enable, restart, level,
    input  tick, tier, tier_changed, phase
  );

  modport slave (
    input  enable, restart, level,
    output tick, tier, tier_changed, phase
  );
endinterface

// File: rtl/speed_tick_gen.sv
// Level-dependent period divider: emits one tick per period, period chosen from a speed tier.
// Optional square-wave phase output is built only when SPEED_TICK_PHASE_EN is defined.
module speed_tick_gen #(
  parameter int unsigned CNT_W  = 27,
  parameter int unsigned DIV_T0 = 100000000,
  parameter int unsigned DIV_T1 = 50000000,
  parameter int unsigned DIV_T2 = 25000000,
  parameter int unsigned DIV_T3 = 12500000,
  parameter int unsigned TH_1   = 3,
  parameter int unsigned TH_2   = 5,
  parameter int unsigned TH_3   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  speed_tick_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_T0 = CNT_W'(DIV_T0 - 1);
  localparam logic [CNT_W-1:0] LAST_T1 = CNT_W'(DIV_T1 - 1);
  localparam logic [CNT_W-1:0] LAST_T2 = CNT_W'(DIV_T2 - 1);
  localparam logic [CNT_W-1:0] LAST_T3 = CNT_W'(DIV_T3 - 1);
  localparam logic [3:0]       TH1_L   = 4'(TH_1);
  localparam logic [3:0]       TH2_L   = 4'(TH_2);
  localparam logic [3:0]       TH3_L   = 4'(TH_3);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic [1:0]       tier_q;
  logic [1:0]       target;
  logic             tick_q;
  logic             tier_changed_q;
  logic             wrap;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    target = 2'd3;
    if (bus.level <= TH1_L)      target = 2'd0;
    else if (bus.level <= TH2_L) target = 2'd1;
    else if (bus.level <= TH3_L) target = 2'd2;
  end

  // The divisor follows the registered tier, so a level change only takes effect after a wrap.
  always_comb begin
    last = LAST_T0;
    case (tier_q)
      2'd1:    last = LAST_T1;
      2'd2:    last = LAST_T2;
      2'd3:    last = LAST_T3;
      default: last = LAST_T0;
    endcase
  end

  assign wrap = bus.enable && (cnt == last);

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt            <= '0;
      tier_q         <= 2'd0;
      tick_q         <= 1'b0;
      tier_changed_q <= 1'b0;
    end else if (bus.restart) begin
      cnt            <= '0;
      tier_q         <= target;
      tier_changed_q <= (target != tier_q);
      tick_q         <= 1'b0;
    end else if (bus.enable) begin
      tick_q <= wrap;
      if (wrap) begin
        cnt            <= '0;
        tier_q         <= target;
        tier_changed_q <= (target != tier_q);
      end else begin
        cnt            <= cnt + 1'b1;
        tier_changed_q <= 1'b0;
      end
    end else begin
      tick_q         <= 1'b0;
      tier_changed_q <= 1'b0;
    end
  end

  assign bus.tick         = tick_q;
  assign bus.tier         = tier_q;
  assign bus.tier_changed = tier_changed_q;

`ifdef SPEED_TICK_PHASE_EN
  logic phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n || bus.restart) phase_q <= 1'b0;
    else if (wrap)             phase_q <= ~phase_q;
  end

  assign bus.phase = phase_q;
`else
  assign bus.phase = 1'b0;
`endif

endmodule

// File: tb/tb_speed_tick_gen.sv
// Table-driven bench for speed_tick_gen with small divisors (8,4,3,2) and default thresholds.
// Expected outputs are queued at drive time and compared one cycle later.
module tb_speed_tick_gen;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  speed_tick_gen_if bus ();

  speed_tick_gen #(
    .CNT_W (4),
    .DIV_T0(8),
    .DIV_T1(4),
    .DIV_T2(3),
    .DIV_T3(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       restart;
    logic       enable;
    logic [3:0] level;
    logic       tick;
    logic [1:0] tier;
    logic       tchg;
  } vec_t;

  typedef struct {
    logic       tick;
    logic [1:0] tier;
    logic       tchg;
    logic       phase;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void add(input logic r, input logic rs, input logic en, input logic [3:0] lv,
                              input logic tk, input logic [1:0] tr, input logic tc);
    vecs.push_back('{r, rs, en, lv, tk, tr, tc});
  endfunction

  // Counts edges until tick is seen; returns -1 if the budget runs out.
  task automatic wait_tick(input int max_cycles, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.tick && n < max_cycles);
    if (!bus.tick) n = -1;
  endtask

  initial begin
    logic ph_exp;
    int   gap;
    int   ticks;
    exp_t e;

    bus.enable  = 1'b0;
    bus.restart = 1'b0;
    bus.level   = 4'd0;
    ph_exp      = 1'b0;

    // reset, then free run at tier 0
    for (int k = 0; k < 2; k++) add(0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(1, 0, 1, 0, (k % 8) == 0, 0, 0);
    // level change mid-period: old period completes, then tier 1
    for (int k = 17; k <= 19; k++) add(1, 0, 1, 2, 0, 0, 0);
    for (int k = 20; k <= 32; k++)
      add(1, 0, 1, 4, (k == 24 || k == 28 || k == 32), (k >= 24) ? 2'd1 : 2'd0, k == 24);
    // back to tier 0, then enable gap at counter 5
    for (int k = 33; k <= 36; k++) add(1, 0, 1, 0, k == 36, (k == 36) ? 2'd0 : 2'd1, k == 36);
    for (int k = 37; k <= 41; k++) add(1, 0, 1, 0, 0, 0, 0);
    for (int k = 42; k <= 46; k++) add(1, 0, 0, 0, 0, 0, 0);
    for (int k = 47; k <= 49; k++) add(1, 0, 1, 0, k == 49, 0, 0);
    // restart at counter 6 with level 9
    for (int k = 50; k <= 55; k++) add(1, 0, 1, 0, 0, 0, 0);
    add(1, 1, 1, 9, 0, 3, 1);
    for (int k = 57; k <= 60; k++) add(1, 0, 1, 9, (k == 58 || k == 60), 3, 0);
    // restart held: tier_changed only on a new target; restart overrides enable=0
    for (int k = 61; k <= 63; k++) add(1, 1, 1, 9, 0, 3, 0);
    add(1, 1, 1, 6, 0, 2, 1);
    add(1, 1, 1, 6, 0, 2, 0);
    add(1, 1, 0, 0, 0, 0, 1);
    for (int k = 67; k <= 74; k++) add(1, 0, 1, 6, k == 74, (k == 74) ? 2'd2 : 2'd0, k == 74);
    add(1, 0, 1, 6, 0, 2, 0);
    // reset mid-period at tier 2; first period afterwards is tier 0 despite level 9
    add(0, 0, 1, 6, 0, 0, 0);
    for (int k = 77; k <= 84; k++) add(1, 0, 1, 9, k == 84, (k == 84) ? 2'd3 : 2'd0, k == 84);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n       = vecs[i].rst_n;
      bus.restart = vecs[i].restart;
      bus.enable  = vecs[i].enable;
      bus.level   = vecs[i].level;
`ifdef SPEED_TICK_PHASE_EN
      if (!vecs[i].rst_n || vecs[i].restart) ph_exp = 1'b0;
      else if (vecs[i].tick)                 ph_exp = ~ph_exp;
`endif
      exp_q.push_back('{vecs[i].tick, vecs[i].tier, vecs[i].tchg, ph_exp});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      check($sformatf("tick[%0d]", i),  bus.tick,         e.tick);
      check($sformatf("tier[%0d]", i),  bus.tier,         e.tier);
      check($sformatf("tchg[%0d]", i),  bus.tier_changed, e.tchg);
      check($sformatf("phase[%0d]", i), bus.phase,        e.phase);
    end

    // tier 3 steady state: tick every 2 cycles
    for (int j = 0; j < 2; j++) begin
      wait_tick(10, gap);
      check($sformatf("t3_interval[%0d]", j), gap, 2);
    end

    // long enable gap: no tick, tier held
    @(negedge clk);
    bus.enable = 1'b0;
    ticks = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      if (bus.tick) ticks++;
    end
    check("gap_ticks", ticks, 0);
    check("gap_tier", bus.tier, 3);

    // resume: counter was 0 after the last tick, so one more period of 2
    @(negedge clk);
    bus.enable = 1'b1;
    wait_tick(10, gap);
    check("resume_interval", gap, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
